// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit bundle: decode/execute/memory hazard inputs from the core,
// stall/flush/bubble controls and status back to the pipeline registers.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_e;
  logic                      mem_read_e;
  logic                      pc_src_e;
  logic                      mem_req_m;
  logic                      mem_ready;
  logic                      stall_f;
  logic                      stall_d;
  logic                      stall_e;
  logic                      stall_m;
  logic                      flush_d;
  logic                      flush_e;
  logic                      bubble_w;
  logic                      mem_err;
  logic [CNT_WIDTH-1:0]      stall_cycles;

  // core side: presents hazard sources, consumes pipeline controls
  modport master (
    output rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, mem_req_m, mem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w,
           mem_err, stall_cycles
  );

  // hazard controller side
  modport slave (
    input  rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, mem_req_m, mem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w,
           mem_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32 core: load-use stalls,
// branch flushes, and memory-wait stalls with a timeout watchdog that
// parks the core in HALT until reset.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               state, state_nx;
  logic [7:0]           wait_cnt, wait_cnt_nx;
  logic                 lu, mw, hold;
  logic                 stall_f, stall_d, stall_e, stall_m;
  logic                 flush_d, flush_e, bubble_w;
  logic                 mem_err;
  logic [CNT_WIDTH-1:0] stall_cycles;

  // x0 is never a real producer, so rd_e==0 can never create a load-use stall
  assign lu   = hz.mem_read_e & (hz.rd_e != '0) &
                ((hz.rd_e == hz.rs1_d) | (hz.rd_e == hz.rs2_d));
  assign mw   = hz.mem_req_m & ~hz.mem_ready;
  assign hold = (state == ST_HALT) | mw;

  // state register and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // next state: count consecutive not-ready cycles, trip HALT on the last one
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      ST_RUN: begin
        wait_cnt_nx = '0;
        if (mw) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mw) begin
          state_nx    = ST_RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ST_HALT;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_RUN;
    endcase
  end

  // pipeline controls; a memory hold freezes E so a pending branch is
  // replayed and applied on the release cycle
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    if (rst) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      bubble_w = 1'b1;
    end else if (hold) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (hz.pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // sticky timeout flag, set on the edge that enters HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    mem_err <= 1'b0;
    else if (state_nx == ST_HALT) mem_err <= 1'b1;
  end

  // saturating count of front-end stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_cycles <= '0;
    else if (stall_f && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end

  assign hz.stall_f      = stall_f;
  assign hz.stall_d      = stall_d;
  assign hz.stall_e      = stall_e;
  assign hz.stall_m      = stall_m;
  assign hz.flush_d      = flush_d;
  assign hz.flush_e      = flush_e;
  assign hz.bubble_w     = bubble_w;
  assign hz.mem_err      = mem_err;
  assign hz.stall_cycles = stall_cycles;

endmodule
